// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_defs
// Description : Shared definitions for the toy RISC-V pipeline: zero
//               constant, load funct3 codes, write-back FSM state encoding
//               and register index width.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int unsigned c_reg_aw = 5;

    localparam logic [31:0] c_zero = 32'h0000_0000;

    // Load funct3 encodings
    localparam logic [2:0] c_funct3_lb  = 3'b000;
    localparam logic [2:0] c_funct3_lh  = 3'b001;
    localparam logic [2:0] c_funct3_lw  = 3'b010;
    localparam logic [2:0] c_funct3_lbu = 3'b100;
    localparam logic [2:0] c_funct3_lhu = 3'b101;

    // Write-back FSM state encoding
    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational load-data alignment and extension. Selects the
//               byte/half/word named by funct3 and offset out of a
//               little-endian memory word, sign- or zero-extends it, and flags
//               misaligned or illegal load types.
// Ports       : word   - memory word (little-endian)
//               funct3 - load type
//               offset - byte offset within the word (addr[1:0])
//               data   - aligned, extended result
//               err    - misaligned or illegal load
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import cpu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{offset, 3'b000} +: 8];
        w_half = offset[1] ? word[31:16] : word[15:0];
        data   = word;
        err    = 1'b0;
        case (funct3)
            c_funct3_lb:  data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_funct3_lbu: data = {{(DATA_W-8){1'b0}}, w_byte};
            c_funct3_lh: begin
                data = {{(DATA_W-16){w_half[15]}}, w_half};
                err  = offset[0];
            end
            c_funct3_lhu: begin
                data = {{(DATA_W-16){1'b0}}, w_half};
                err  = offset[0];
            end
            c_funct3_lw: begin
                data = word;
                err  = (offset != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

endmodule : load_extract
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : Write-back stage. ALU results are written to the register
//               file one cycle after acceptance. Loads are issued to the
//               memory controller; the stage stalls until mem_done, then
//               aligns/extends the returned word and writes it back.
//               Misaligned/illegal loads retire with a load_err pulse and
//               never touch memory.
// Ports       : clk, rst (async, active-low), flush
//               in_*          - instruction from MEM stage (valid/ready)
//               mem_*         - load request/response to memory controller
//               write_*       - register-file write port
//               load_err      - one-cycle pulse on a bad load
//               retire_cnt    - retired instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import cpu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = c_reg_aw
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rd_we,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_is_load,
    input  logic [2:0]        in_funct3,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              write_enable,
    output logic [REG_AW-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              load_err,
    output logic [31:0]       retire_cnt
);

    wb_state_e         r_state;
    wb_state_e         w_state_nxt;

    logic [REG_AW-1:0] r_rd;
    logic              r_rd_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;

    logic [2:0]        w_ext_funct3;
    logic [1:0]        w_ext_offset;
    logic [DATA_W-1:0] w_ext_data;
    logic              w_ext_err;
    logic              w_accept;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready && !flush;

    // One extractor serves both uses: in IDLE it checks the incoming load
    // for alignment/legality, in WAIT_LOAD it aligns the returned data
    // using the latched load type.
    assign w_ext_funct3 = in_ready ? in_funct3 : r_funct3;
    assign w_ext_offset = in_ready ? in_alu_result[1:0] : r_offset;

    load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .word   (mem_rdata),
        .funct3 (w_ext_funct3),
        .offset (w_ext_offset),
        .data   (w_ext_data),
        .err    (w_ext_err)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush dominates everything
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_is_load && !w_ext_err) begin
                        w_state_nxt = WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if (mem_done) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            load_err     <= 1'b0;
            retire_cnt   <= c_zero;
            r_rd         <= '0;
            r_rd_we      <= 1'b0;
            r_funct3     <= 3'b000;
            r_offset     <= 2'b00;
        end else begin
            // Strobes are single-cycle unless re-armed below
            write_enable <= 1'b0;
            load_err     <= 1'b0;

            if (flush) begin
                mem_req <= 1'b0;
            end else if (w_accept) begin
                if (!in_is_load) begin
                    write_enable <= in_rd_we && (in_rd_addr != '0);
                    write_addr   <= in_rd_addr;
                    write_data   <= in_alu_result;
                    retire_cnt   <= retire_cnt + 32'd1;
                end else if (w_ext_err) begin
                    load_err     <= 1'b1;
                    retire_cnt   <= retire_cnt + 32'd1;
                end else begin
                    r_rd     <= in_rd_addr;
                    r_rd_we  <= in_rd_we;
                    r_funct3 <= in_funct3;
                    r_offset <= in_alu_result[1:0];
                    mem_req  <= 1'b1;
                    mem_addr <= {in_alu_result[ADDR_W-1:2], 2'b00};
                end
            end else if ((r_state == WAIT_LOAD) && mem_done) begin
                mem_req      <= 1'b0;
                write_enable <= r_rd_we && (r_rd != '0);
                write_addr   <= r_rd;
                write_data   <= w_ext_data;
                retire_cnt   <= retire_cnt + 32'd1;
            end
        end
    end

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_rd_we;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_alu_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        load_err;
    logic [31:0] retire_cnt;

    int n_pass;
    int n_total;
    logic [31:0] exp_retire;

    mem_wb_stage #(
        .DATA_W (32),
        .ADDR_W (32),
        .REG_AW (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd_we      (in_rd_we),
        .in_rd_addr    (in_rd_addr),
        .in_alu_result (in_alu_result),
        .in_is_load    (in_is_load),
        .in_funct3     (in_funct3),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .load_err      (load_err),
        .retire_cnt    (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic present(input logic ld, input logic [2:0] f3, input logic we,
                           input logic [4:0] rd, input logic [31:0] val);
        in_valid      = 1'b1;
        in_is_load    = ld;
        in_funct3     = f3;
        in_rd_we      = we;
        in_rd_addr    = rd;
        in_alu_result = val;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        mem_done   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        in_rd_we = 1'b0; in_rd_addr = '0; in_alu_result = '0;
        in_funct3 = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({mem_req, mem_addr, write_enable, write_addr, write_data, load_err, retire_cnt, in_ready}
            !== {1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b1})
            $display("FAIL reset_state: got req=%b addr=%h we=%b wa=%h wd=%h err=%b cnt=%0d rdy=%b, want all 0 rdy=1",
                     mem_req, mem_addr, write_enable, write_addr, write_data, load_err, retire_cnt, in_ready);
        else n_pass++;
        rst = 1'b1;
        exp_retire = 0;
        @(negedge clk);
    endtask

    task automatic test_alu(input logic we, input logic [4:0] rd, input logic [31:0] val,
                            input logic exp_we);
        present(1'b0, 3'b000, we, rd, val);
        @(negedge clk);
        idle_inputs();
        exp_retire++;
        n_total++;
        if ({write_enable, write_addr, write_data, retire_cnt} !== {exp_we, rd, val, exp_retire})
            $display("FAIL alu_write rd=%0d: got we=%b wa=%0d wd=%h cnt=%0d, want we=%b wa=%0d wd=%h cnt=%0d",
                     rd, write_enable, write_addr, write_data, retire_cnt, exp_we, rd, val, exp_retire);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({write_enable, retire_cnt} !== {1'b0, exp_retire})
            $display("FAIL alu_pulse: got we=%b cnt=%0d, want we=0 cnt=%0d",
                     write_enable, retire_cnt, exp_retire);
        else n_pass++;
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_data);
        present(1'b1, f3, 1'b1, rd, addr);
        @(negedge clk);
        idle_inputs();
        n_total++;
        if ({mem_req, mem_addr, in_ready, write_enable} !== {1'b1, {addr[31:2], 2'b00}, 1'b0, 1'b0})
            $display("FAIL load_issue f3=%0d: got req=%b addr=%h rdy=%b we=%b, want req=1 addr=%h rdy=0 we=0",
                     f3, mem_req, mem_addr, in_ready, write_enable, {addr[31:2], 2'b00});
        else n_pass++;
        // Hold a cycle to show the request is held until mem_done
        @(negedge clk);
        n_total++;
        if ({mem_req, retire_cnt} !== {1'b1, exp_retire})
            $display("FAIL load_hold: got req=%b cnt=%0d, want req=1 cnt=%0d", mem_req, retire_cnt, exp_retire);
        else n_pass++;
        mem_done  = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_done  = 1'b0;
        exp_retire++;
        n_total++;
        if ({mem_req, write_enable, write_addr, write_data, retire_cnt, in_ready}
            !== {1'b0, 1'b1, rd, exp_data, exp_retire, 1'b1})
            $display("FAIL load_wb f3=%0d: got req=%b we=%b wa=%0d wd=%h cnt=%0d rdy=%b, want req=0 we=1 wa=%0d wd=%h cnt=%0d rdy=1",
                     f3, mem_req, write_enable, write_addr, write_data, retire_cnt, in_ready, rd, exp_data, exp_retire);
        else n_pass++;
    endtask

    task automatic test_bad_load(input logic [2:0] f3, input logic [31:0] addr);
        present(1'b1, f3, 1'b1, 5'd7, addr);
        @(negedge clk);
        idle_inputs();
        exp_retire++;
        n_total++;
        if ({load_err, mem_req, write_enable, in_ready, retire_cnt} !== {1'b1, 1'b0, 1'b0, 1'b1, exp_retire})
            $display("FAIL bad_load f3=%0d addr=%h: got err=%b req=%b we=%b rdy=%b cnt=%0d, want err=1 req=0 we=0 rdy=1 cnt=%0d",
                     f3, addr, load_err, mem_req, write_enable, in_ready, retire_cnt, exp_retire);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({load_err, mem_req} !== 2'b00)
            $display("FAIL bad_load_pulse: got err=%b req=%b, want 0 0", load_err, mem_req);
        else n_pass++;
    endtask

    task automatic test_idle_done();
        mem_done  = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_done = 1'b0;
        n_total++;
        if ({write_enable, retire_cnt, mem_req} !== {1'b0, exp_retire, 1'b0})
            $display("FAIL idle_done: got we=%b cnt=%0d req=%b, want we=0 cnt=%0d req=0",
                     write_enable, retire_cnt, mem_req, exp_retire);
        else n_pass++;
    endtask

    task automatic test_flush_done();
        present(1'b1, 3'b010, 1'b1, 5'd9, 32'h0000_0300);
        @(negedge clk);
        idle_inputs();
        flush     = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = 32'h1111_2222;
        // A same-edge instruction must not be accepted either
        present(1'b0, 3'b000, 1'b1, 5'd3, 32'h5555_5555);
        @(negedge clk);
        idle_inputs();
        n_total++;
        if ({write_enable, mem_req, in_ready, retire_cnt} !== {1'b0, 1'b0, 1'b1, exp_retire})
            $display("FAIL flush_done: got we=%b req=%b rdy=%b cnt=%0d, want we=0 req=0 rdy=1 cnt=%0d",
                     write_enable, mem_req, in_ready, retire_cnt, exp_retire);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({write_enable, retire_cnt} !== {1'b0, exp_retire})
            $display("FAIL flush_after: got we=%b cnt=%0d, want we=0 cnt=%0d", write_enable, retire_cnt, exp_retire);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        present(1'b1, 3'b010, 1'b1, 5'd4, 32'h0000_0400);
        @(negedge clk);
        idle_inputs();
        n_total++;
        if (mem_req !== 1'b1)
            $display("FAIL async_pre: got req=%b, want 1", mem_req);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if ({mem_req, write_enable, retire_cnt, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1})
            $display("FAIL async_reset: got req=%b we=%b cnt=%0d rdy=%b, want req=0 we=0 cnt=0 rdy=1",
                     mem_req, write_enable, retire_cnt, in_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        exp_retire = 0;
        @(negedge clk);
        test_alu(1'b1, 5'd6, 32'hCAFE_0001, 1'b1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_retire = 0;
        test_reset();
        test_alu(1'b1, 5'd5, 32'h0000_1234, 1'b1);
        test_alu(1'b1, 5'd0, 32'h0000_9999, 1'b0);
        test_alu(1'b0, 5'd8, 32'h0000_7777, 1'b0);
        test_load(3'b000, 5'd10, 32'h0000_0101, 32'h1234_F678, 32'hFFFF_FFF6);
        test_load(3'b100, 5'd11, 32'h0000_0101, 32'h1234_F678, 32'h0000_00F6);
        test_load(3'b001, 5'd12, 32'h0000_0102, 32'h1234_F678, 32'h0000_1234);
        test_load(3'b001, 5'd13, 32'h0000_0100, 32'h1234_F678, 32'hFFFF_F678);
        test_load(3'b101, 5'd14, 32'h0000_0100, 32'h1234_F678, 32'h0000_F678);
        test_load(3'b000, 5'd15, 32'h0000_0103, 32'h8234_F678, 32'hFFFF_FF82);
        test_load(3'b010, 5'd16, 32'h0000_0200, 32'h89AB_CDEF, 32'h89AB_CDEF);
        test_bad_load(3'b010, 32'h0000_0202);
        test_bad_load(3'b101, 32'h0000_0101);
        test_bad_load(3'b011, 32'h0000_0100);
        test_idle_done();
        test_flush_done();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire
